// File: rtl/sub_seq_32.sv
// sub_seq_32: byte-serial two's-complement subtractor (A - B).
// Each RUN cycle one SLICE-wide chunk of A + ~B + carry is formed by a
// carry-select adder slice; the slice carry-out is held in r_carry for the
// next chunk. Compare flags are produced on the last chunk.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for operands; in_ready=1
// RUN    | one slice per cycle, r_idx = slice being processed
// DONE   | result and flags valid; held until out_ready
module sub_seq_32 #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    // Operands are shifted right each RUN cycle so the active chunk is
    // always in the low SLICE bits; B is stored already inverted.
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b_n;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;
    logic [WIDTH-1:0] r_result;
    logic             r_ne;
    logic             r_lt;
    logic             r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [SLICE-1:0] w_a_slice;
    logic [SLICE-1:0] w_b_slice;
    logic [SLICE:0]   w_sum0;
    logic [SLICE:0]   w_sum1;
    logic [SLICE:0]   w_sum;
    logic             w_cin_msb;
    logic             w_ovf;
    logic [WIDTH-1:0] w_result_nxt;

    assign w_accept  = (r_state == S_IDLE) && in_valid;
    assign w_last    = (r_idx == LAST_IDX);
    assign w_a_slice = r_a[SLICE-1:0];
    assign w_b_slice = r_b_n[SLICE-1:0];

    // Carry-select slice: both carry-in cases precomputed, registered carry picks one.
    always_comb begin
        w_sum0    = {1'b0, w_a_slice} + {1'b0, w_b_slice};
        w_sum1    = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{SLICE{1'b0}}, 1'b1};
        w_sum     = r_carry ? w_sum1 : w_sum0;
        // Carry into the slice MSB recovered from the MSB sum bit.
        w_cin_msb = w_a_slice[SLICE-1] ^ w_b_slice[SLICE-1] ^ w_sum[SLICE-1];
        w_ovf     = w_cin_msb ^ w_sum[SLICE];
    end

    // Result with the current chunk merged in; higher chunks keep old contents.
    always_comb begin
        w_result_nxt = r_result;
        for (int k = 0; k < NSLICE; k++) begin
            if (r_idx == IDXW'(k)) begin
                w_result_nxt[k*SLICE +: SLICE] = w_sum[SLICE-1:0];
            end
        end
    end

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (in_valid)  w_state_nxt = S_RUN;
            S_RUN:  if (w_last)    w_state_nxt = S_DONE;
            S_DONE: if (out_ready) w_state_nxt = S_IDLE;
            default:               w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs are pure state decodes.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath: operand capture, per-slice accumulation, flags on the last slice.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b_n    <= '0;
            r_carry  <= 1'b1;
            r_idx    <= '0;
            r_result <= '0;
            r_ne     <= 1'b0;
            r_lt     <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_accept) begin
            r_a     <= data_operandA;
            r_b_n   <= ~data_operandB;
            r_carry <= 1'b1;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_a      <= r_a >> SLICE;
            r_b_n    <= r_b_n >> SLICE;
            r_carry  <= w_sum[SLICE];
            r_result <= w_result_nxt;
            if (w_last) begin
                r_idx <= '0;
                r_ovf <= w_ovf;
                r_lt  <= w_sum[SLICE-1] ^ w_ovf;
                r_ne  <= |w_result_nxt;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign data_result = r_result;
    assign isNotEqual  = r_ne;
    assign isLessThan  = r_lt;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_sub_seq_32.sv
// Testbench for sub_seq_32: directed vector table, handshake/reset corner
// sequences, and randomized operands against an arithmetic reference model.
module tb_sub_seq_32;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_operandA;
    logic [31:0] data_operandB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_result;
    logic        isNotEqual;
    logic        isLessThan;
    logic        overflow;

    int n_checks;
    int n_fail;

    sub_seq_32 dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_operandA(data_operandA),
        .data_operandB(data_operandB),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .data_result  (data_result),
        .isNotEqual   (isNotEqual),
        .isLessThan   (isLessThan),
        .overflow     (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ne;
        logic        lt;
        logic        ov;
    } vec_t;

    localparam int NV = 10;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: true signed difference in 64 bits; overflow when it does not
    // survive truncation to 32 bits.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ne,
                                  output logic lt, output logic ov);
        longint sa, sb, d, rt;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        d  = sa - sb;
        r  = a - b;
        rt = longint'($signed(r));
        ne = (r != 32'd0);
        lt = (sa < sb);
        ov = (d != rt);
    endfunction

    // Present operands, wait for out_valid; leaves the DUT in DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) chk("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid      = 1'b1;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock); #1;
        in_valid      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        n = 0;
        while (!out_valid && n < 20) begin
            chk("in_ready_busy", {31'd0, in_ready}, 32'd0);
            @(posedge clock); #1;
            n++;
        end
        lat = n;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("out_valid_fall", {31'd0, out_valid}, 32'd0);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    endtask

    task automatic check_result(input string tag, input logic [31:0] r, input logic ne,
                                input logic lt, input logic ov, input int lat);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_result"}, data_result, r);
        chk({tag, "_ne"}, {31'd0, isNotEqual}, {31'd0, ne});
        chk({tag, "_lt"}, {31'd0, isLessThan}, {31'd0, lt});
        chk({tag, "_ovf"}, {31'd0, overflow}, {31'd0, ov});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        logic [31:0] r, held;
        logic        ne, lt, ov;
        logic [31:0] ra, rb;

        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        data_operandA = '0;
        data_operandB = '0;

        vecs[0] = '{32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1};
        vecs[3] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1'b1};
        vecs[4] = '{32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_00FF, 32'h0000_00FF, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 1'b1};
        vecs[9] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0};

        #12;
        chk("rst_result", data_result, 32'd0);
        chk("rst_ne", {31'd0, isNotEqual}, 32'd0);
        chk("rst_lt", {31'd0, isLessThan}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].a, vecs[i].b, lat);
            check_result($sformatf("vec%0d", i), vecs[i].res, vecs[i].ne, vecs[i].lt, vecs[i].ov, lat);
            release_out();
        end

        // Output hold with out_ready low while new operands are offered.
        run_op(32'h0000_1000, 32'h0000_0001, lat);
        held = data_result;
        chk("hold_first_result", held, 32'h0000_0FFF);
        in_valid      = 1'b1;
        data_operandA = 32'h0000_0009;
        data_operandB = 32'h0000_000C;
        for (int c = 0; c < 5; c++) begin
            @(posedge clock); #1;
            chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
            chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
            chk("hold_result", data_result, held);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("hold_rel_out_valid", {31'd0, out_valid}, 32'd0);
        chk("hold_rel_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h0BAD_F00D;
        chk("hold_second_accepted", {31'd0, in_ready}, 32'd0);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clock); #1;
            lat++;
        end
        model(32'h0000_0009, 32'h0000_000C, r, ne, lt, ov);
        check_result("hold_second", r, ne, lt, ov, lat);
        release_out();

        // Asynchronous reset during the second RUN cycle.
        in_valid      = 1'b1;
        data_operandA = 32'h1111_2222;
        data_operandB = 32'h0000_3333;
        @(posedge clock); #1;
        in_valid = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("arst_result", data_result, 32'd0);
        chk("arst_ne", {31'd0, isNotEqual}, 32'd0);
        chk("arst_lt", {31'd0, isLessThan}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        run_op(32'h0000_0010, 32'h0000_0020, lat);
        model(32'h0000_0010, 32'h0000_0020, r, ne, lt, ov);
        check_result("post_rst", r, ne, lt, ov, lat);
        release_out();

        // Randomized operands against the reference model.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            case (i % 4)
                0:       rb = ra;
                1:       rb = ra ^ (32'd1 << $urandom_range(31, 0));
                2:       rb = {~ra[31], ra[30:0]} ^ 32'($urandom_range(3, 0));
                default: rb = $urandom;
            endcase
            run_op(ra, rb, lat);
            model(ra, rb, r, ne, lt, ov);
            check_result($sformatf("rnd%0d", i), r, ne, lt, ov, lat);
            release_out();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
